// File: rtl/approx_wallace_mac.sv
// Pipelined unsigned multiply-accumulate with a Wallace-style reduction and framed results.
// Define APPROX_WALLACE_COLS_EN to OR-reduce the low APPROX_COLS product columns.
module approx_wallace_mac #(
  parameter int WIDTH       = 8,
  parameter int ACC_WIDTH   = 2*WIDTH+4,
  parameter int APPROX_COLS = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [WIDTH-1:0]     a,
  input  logic [WIDTH-1:0]     b,
  input  logic                 in_last,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [ACC_WIDTH-1:0] out_acc,
  output logic [15:0]          out_count,
  output logic                 out_ovf
);

  localparam int PW = 2*WIDTH;
`ifdef APPROX_WALLACE_COLS_EN
  localparam int AC = APPROX_COLS;
`else
  // APPROX_COLS has no effect in the exact build.
  localparam int AC = APPROX_COLS * 0;
`endif
  localparam logic [PW-1:0] LO_MASK = PW'((64'd1 << AC) - 64'd1);
  localparam int NG = WIDTH / 3;
  localparam int NR = 2*NG + (WIDTH % 3);

  typedef enum logic [1:0] {ACCUM, DRAIN, HOLD} state_e;

  state_e               state_q, state_d;
  logic [ACC_WIDTH-1:0] acc_q, acc_d;
  logic [15:0]          cnt_q, cnt_d;
  logic                 ovf_q, ovf_d;

  logic                 s1_vld_q, s1_last_q;
  logic [PW-1:0]        s1_rows_q [NR];
  logic [PW-1:0]        s1_lo_q;
  logic                 s2_vld_q, s2_last_q;
  logic [PW-1:0]        s2_prod_q;

  logic                 accept;
  logic [PW-1:0]        pp [WIDTH];
  logic [PW-1:0]        l1_d [NR];
  logic [PW-1:0]        lo_or_d;
  logic [PW-1:0]        prod_d;
  logic [ACC_WIDTH:0]   acc_sum;

  assign in_ready  = (state_q == ACCUM);
  assign out_valid = (state_q == HOLD);
  assign accept    = in_valid && in_ready;
  assign out_acc   = acc_q;
  assign out_count = cnt_q;
  assign out_ovf   = ovf_q;

  // Stage 1: partial products, low-column OR split, one layer of 3:2 compressors.
  always_comb begin
    lo_or_d = '0;
    for (int unsigned i = 0; i < WIDTH; i++) begin
      pp[i]   = (b[i] ? PW'(a) : '0) << i;
      lo_or_d = lo_or_d | (pp[i] & LO_MASK);
      pp[i]   = pp[i] & ~LO_MASK;
    end
    for (int unsigned g = 0; g < NG; g++) begin
      l1_d[2*g]   = pp[3*g] ^ pp[3*g+1] ^ pp[3*g+2];
      l1_d[2*g+1] = ((pp[3*g] & pp[3*g+1]) | (pp[3*g] & pp[3*g+2]) |
                     (pp[3*g+1] & pp[3*g+2])) << 1;
    end
    for (int unsigned r = 0; r < WIDTH % 3; r++) begin
      l1_d[2*NG+r] = pp[3*NG+r];
    end
  end

  // Stage 2: finish reduction; the high rows are zero in the low columns so OR merges them.
  always_comb begin
    prod_d = '0;
    for (int unsigned r = 0; r < NR; r++) begin
      prod_d = prod_d + s1_rows_q[r];
    end
    prod_d = prod_d | s1_lo_q;
  end

  assign acc_sum = {1'b0, acc_q} + (ACC_WIDTH+1)'(s2_prod_q);

  always_comb begin
    state_d = state_q;
    acc_d   = acc_q;
    cnt_d   = cnt_q;
    ovf_d   = ovf_q;
    case (state_q)
      ACCUM:   if (accept && in_last) state_d = DRAIN;
      DRAIN:   if (s2_vld_q && s2_last_q) state_d = HOLD;
      HOLD:    if (out_ready) state_d = ACCUM;
      default: state_d = ACCUM;
    endcase
    if (state_q == HOLD && out_ready) begin
      acc_d = '0;
      cnt_d = '0;
      ovf_d = 1'b0;
    end else begin
      if (s2_vld_q) begin
        acc_d = acc_sum[ACC_WIDTH-1:0];
        ovf_d = ovf_q | acc_sum[ACC_WIDTH];
      end
      if (accept && cnt_q != 16'hFFFF) cnt_d = cnt_q + 16'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= ACCUM;
      acc_q     <= '0;
      cnt_q     <= '0;
      ovf_q     <= 1'b0;
      s1_vld_q  <= 1'b0;
      s1_last_q <= 1'b0;
      s2_vld_q  <= 1'b0;
      s2_last_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      acc_q     <= acc_d;
      cnt_q     <= cnt_d;
      ovf_q     <= ovf_d;
      s1_vld_q  <= accept;
      s1_last_q <= accept && in_last;
      s2_vld_q  <= s1_vld_q;
      s2_last_q <= s1_vld_q && s1_last_q;
    end
  end

  always_ff @(posedge clk) begin
    if (accept) begin
      for (int unsigned r = 0; r < NR; r++) s1_rows_q[r] <= l1_d[r];
      s1_lo_q <= lo_or_d;
    end
    if (s1_vld_q) s2_prod_q <= prod_d;
  end

endmodule

// File: tb/tb_approx_wallace_mac.sv
// Directed and random-frame bench for approx_wallace_mac: default, 16-bit accumulator
// and zero-approximation-column instances share one stimulus stream.
module tb_approx_wallace_mac;

`ifdef APPROX_WALLACE_COLS_EN
  localparam int unsigned EXP_29    = 65006;  // 15 + 64991
  localparam int unsigned EXP_FF    = 64991;
  localparam int unsigned EXP_2FF   = 129982;
  localparam int unsigned EXP_2FF16 = 64446;
`else
  localparam int unsigned EXP_29    = 65040;
  localparam int unsigned EXP_FF    = 65025;
  localparam int unsigned EXP_2FF   = 130050;
  localparam int unsigned EXP_2FF16 = 64514;
`endif

  logic        clk = 1'b0;
  logic        rst, in_valid, in_last, out_ready;
  logic [7:0]  a, b;
  logic        rdy, vld, ovf, rdy16, vld16, ovf16, rdy0, vld0, ovf0;
  logic [19:0] acc, acc0;
  logic [15:0] acc16, cnt, cnt16, cnt0;

  int unsigned n_cmp = 0;
  int unsigned n_bad = 0;

  always #5 clk = ~clk;

  approx_wallace_mac u_dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(rdy), .a(a), .b(b),
    .in_last(in_last), .out_valid(vld), .out_ready(out_ready), .out_acc(acc),
    .out_count(cnt), .out_ovf(ovf));

  approx_wallace_mac #(.ACC_WIDTH(16)) u_dut16 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(rdy16), .a(a), .b(b),
    .in_last(in_last), .out_valid(vld16), .out_ready(out_ready), .out_acc(acc16),
    .out_count(cnt16), .out_ovf(ovf16));

  approx_wallace_mac #(.APPROX_COLS(0)) u_ac0 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(rdy0), .a(a), .b(b),
    .in_last(in_last), .out_valid(vld0), .out_ready(out_ready), .out_acc(acc0),
    .out_count(cnt0), .out_ovf(ovf0));

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [7:0] av, input logic [7:0] bv, input logic last);
    bit done = 0;
    in_valid = 1'b1;
    a        = av;
    b        = bv;
    in_last  = last;
    for (int k = 0; k < 50 && !done; k++) begin
      if (rdy) done = 1;
      tick();
    end
    in_valid = 1'b0;
    if (!done) check("send_timeout", 0, 1);
  endtask

  // Waits for out_valid, captures all three instances, then completes the handshake.
  task automatic get_result(input string tag, output logic [19:0] r_acc, output logic [15:0] r_cnt,
                            output logic r_ovf, output logic [15:0] r_acc16, output logic r_ovf16,
                            output logic [19:0] r_acc0);
    bit seen = 0;
    for (int k = 0; k < 40 && !seen; k++) begin
      if (vld) seen = 1;
      else tick();
    end
    check({tag, "_timeout"}, seen, 1);
    r_acc = acc; r_cnt = cnt; r_ovf = ovf; r_acc16 = acc16; r_ovf16 = ovf16; r_acc0 = acc0;
    if (seen) begin
      out_ready = 1'b1;
      tick();
      out_ready = 1'b0;
    end
  endtask

  function automatic int unsigned model_prod(input int unsigned av, input int unsigned bv);
`ifdef APPROX_WALLACE_COLS_EN
    int unsigned hi, lo, bits;
    hi = 0;
    lo = 0;
    for (int j = 0; j < 16; j++) begin
      bits = 0;
      for (int i = 0; i < 8; i++)
        if (j - i >= 0 && j - i < 8) bits += ((bv >> i) & 1) & ((av >> (j - i)) & 1);
      if (j < 4) begin
        if (bits != 0) lo |= (1 << j);
      end else begin
        hi += bits << j;
      end
    end
    return hi + lo;
`else
    return av * bv;
`endif
  endfunction

  logic [19:0] r_acc, r_acc0;
  logic [15:0] r_cnt, r_acc16;
  logic        r_ovf, r_ovf16;
  int unsigned exp_sum, exact_sum, nb;
  logic [7:0]  ra, rb;

  initial begin
    rst = 1'b1; in_valid = 1'b0; in_last = 1'b0; out_ready = 1'b0; a = '0; b = '0;
    tick();
    tick();
    check("rst_in_ready", rdy, 1);
    check("rst_out_valid", vld, 0);
    check("rst_out_acc", acc, 0);
    check("rst_out_count", cnt, 0);
    check("rst_out_ovf", ovf, 0);
    rst = 1'b0;
    tick();

    // Two-beat frame and result latency
    send(8'd3, 8'd5, 1'b0);
    send(8'd255, 8'd255, 1'b1);
    check("drain_in_ready", rdy, 0);
    check("lat_valid_e1", vld, 0);
    tick();
    check("lat_valid_e2", vld, 0);
    tick();
    check("lat_valid_e3", vld, 1);
    get_result("f29", r_acc, r_cnt, r_ovf, r_acc16, r_ovf16, r_acc0);
    check("f29_acc", r_acc, EXP_29);
    check("f29_count", r_cnt, 2);
    check("f29_ovf", r_ovf, 0);
    check("f29_acc_ac0", r_acc0, 65040);
    check("f29_released", vld, 0);
    check("f29_cleared_acc", acc, 0);
    check("f29_cleared_cnt", cnt, 0);
    check("f29_ready_again", rdy, 1);

    // Single-beat frames
    send(8'd255, 8'd255, 1'b1);
    get_result("ff", r_acc, r_cnt, r_ovf, r_acc16, r_ovf16, r_acc0);
    check("ff_acc", r_acc, EXP_FF);
    check("ff_count", r_cnt, 1);
    check("ff_acc_ac0", r_acc0, 65025);
    send(8'd1, 8'd1, 1'b1);
    get_result("one", r_acc, r_cnt, r_ovf, r_acc16, r_ovf16, r_acc0);
    check("one_acc", r_acc, 1);
    check("one_count", r_cnt, 1);

    // Wrap of a 16-bit accumulator, then a clean frame
    send(8'd255, 8'd255, 1'b0);
    send(8'd255, 8'd255, 1'b1);
    get_result("wrap", r_acc, r_cnt, r_ovf, r_acc16, r_ovf16, r_acc0);
    check("wrap_acc16", r_acc16, EXP_2FF16);
    check("wrap_ovf16", r_ovf16, 1);
    check("wrap_acc20", r_acc, EXP_2FF);
    check("wrap_ovf20", r_ovf, 0);
    send(8'd2, 8'd2, 1'b1);
    get_result("post", r_acc, r_cnt, r_ovf, r_acc16, r_ovf16, r_acc0);
    check("post_acc16", r_acc16, 4);
    check("post_ovf16", r_ovf16, 0);

    // Back-to-back beats, result held while out_ready stays low
    for (int i = 0; i < 4; i++) send(8'd1, 8'd1, i == 3);
    check("b2b_ready_e1", rdy, 0);
    tick();
    check("b2b_ready_e2", rdy, 0);
    tick();
    for (int i = 0; i < 5; i++) begin
      check("hold_ready", rdy, 0);
      check("hold_valid", vld, 1);
      check("hold_acc", acc, 4);
      check("hold_count", cnt, 4);
      tick();
    end
    get_result("b2b", r_acc, r_cnt, r_ovf, r_acc16, r_ovf16, r_acc0);
    check("b2b_acc", r_acc, 4);
    check("b2b_count", r_cnt, 4);

    // Reset mid-frame discards in-flight beats
    send(8'd10, 8'd10, 1'b0);
    send(8'd20, 8'd20, 1'b0);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("midrst_acc", acc, 0);
    check("midrst_count", cnt, 0);
    send(8'd1, 8'd2, 1'b1);
    get_result("midrst", r_acc, r_cnt, r_ovf, r_acc16, r_ovf16, r_acc0);
    check("midrst_res_acc", r_acc, 2);
    check("midrst_res_count", r_cnt, 1);

    // Reset while holding a result abandons it
    send(8'd5, 8'd5, 1'b1);
    tick();
    tick();
    check("holdrst_pre_valid", vld, 1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("holdrst_valid", vld, 0);
    check("holdrst_acc", acc, 0);
    check("holdrst_ready", rdy, 1);

    // Beat counter saturation
    for (int i = 0; i < 65537; i++) send(8'd1, 8'd1, 1'b0);
    send(8'd1, 8'd1, 1'b1);
    get_result("sat", r_acc, r_cnt, r_ovf, r_acc16, r_ovf16, r_acc0);
    check("sat_count", r_cnt, 65535);
    check("sat_acc", r_acc, 65538);

    // Random frames: zero-column instance must be exact, default instance follows the model
    for (int f = 0; f < 1000; f++) begin
      nb = $urandom_range(3, 1);
      exp_sum = 0;
      exact_sum = 0;
      for (int unsigned i = 0; i < nb; i++) begin
        ra = 8'($urandom_range(255, 0));
        rb = 8'($urandom_range(255, 0));
        exp_sum += model_prod(ra, rb);
        exact_sum += ra * rb;
        send(ra, rb, i == nb - 1);
      end
      get_result("rnd", r_acc, r_cnt, r_ovf, r_acc16, r_ovf16, r_acc0);
      check("rnd_acc_ac0", r_acc0, exact_sum);
      check("rnd_acc", r_acc, exp_sum);
      check("rnd_count", r_cnt, nb);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/approx_wallace_mac.md
APPROX_WALLACE_MAC -- requirements
Module: approx_wallace_mac

Interface
REQ-001 SHALL have parameter WIDTH, default 8, operand width in bits (range 4..16).
REQ-002 SHALL have parameter ACC_WIDTH, default 2*WIDTH+4, accumulator width in bits (minimum 2*WIDTH).
REQ-003 SHALL have parameter APPROX_COLS, default 4, number of low product columns reduced approximately (range 0..WIDTH).
REQ-004 SHALL have port clk, input, 1, sole clock; all state updates on rising edge.
REQ-005 SHALL have port rst, input, 1, synchronous active-high reset.
REQ-006 SHALL have ports in_valid (input, 1) and in_ready (output, 1): beat handshake; a beat transfers when both are high on a clk edge.
REQ-007 SHALL have ports a and b, input, WIDTH each, unsigned multiplicand and multiplier.
REQ-008 SHALL have port in_last, input, 1, marking the final beat of a frame.
REQ-009 SHALL have ports out_valid (output, 1) and out_ready (input, 1): result handshake.
REQ-010 SHALL have port out_acc, output, ACC_WIDTH, frame sum of products.
REQ-011 SHALL have port out_count, output, 16, beats in the frame, saturating at 65535.
REQ-012 SHALL have port out_ovf, output, 1, sticky accumulator wrap flag for the frame.

Function
REQ-013 SHALL compute each beat's product through a 3-stage pipeline: S1 partial products plus first Wallace reduction layer (registered), S2 remaining reduction plus carry-propagate add (registered), S3 accumulate.
REQ-014 SHALL add an accepted beat's product into the accumulator on the 3rd rising edge after acceptance; one beat per cycle sustained.
REQ-015 SHALL implement FSM states ACCUM, DRAIN, HOLD; in_ready = 1 only in ACCUM.
REQ-016 ACCUM -> DRAIN when a beat with in_last=1 is accepted; DRAIN -> HOLD on the edge that accumulates that beat; HOLD -> ACCUM on the edge where out_valid and out_ready are both high.
REQ-017 In HOLD, out_valid SHALL be 1 and out_acc, out_count, out_ovf SHALL be held stable until the handshake; out_valid SHALL be 0 in ACCUM and DRAIN.
REQ-018 On HOLD -> ACCUM, accumulator, beat counter and overflow flag SHALL be cleared so the next frame starts at zero; first beat may be accepted on the following cycle.
REQ-019 Accumulation SHALL wrap modulo 2^ACC_WIDTH; any carry out of bit ACC_WIDTH-1 SHALL set the overflow flag until the frame is cleared.
REQ-020 A single-beat frame (first beat has in_last=1) SHALL be legal and produce out_count=1.
REQ-021 in_valid, a, b, in_last SHALL be ignored when in_ready=0.
REQ-022 Beat counter SHALL increment on acceptance and saturate at 65535.

Reset
REQ-023 On rst=1 at a clk edge: state SHALL become ACCUM; accumulator, counter, overflow flag, all pipeline valid bits SHALL be 0; in-flight beats SHALL be discarded.
REQ-024 Output values during and after reset: in_ready=1, out_valid=0, out_acc=0, out_count=0, out_ovf=0.
REQ-025 rst asserted mid-frame or in HOLD SHALL abandon the frame with no result presented.

Configuration
REQ-026 Macro APPROX_WALLACE_COLS_EN SHALL control approximation.
REQ-027 Defined: each product column j < APPROX_COLS SHALL be reduced to the logical OR of its partial-product bits, generating no carry into column j+1; columns >= APPROX_COLS SHALL be reduced exactly.
REQ-028 Not defined: all columns SHALL be reduced exactly (product = a*b); APPROX_COLS SHALL be ignored.

Verification
REQ-029 Exact build, defaults: beats (3,5),(255,255,last) -> one HOLD result out_acc=65040, out_count=2, out_ovf=0, out_valid 3 cycles after last accepted.
REQ-030 Approx build, WIDTH=8, APPROX_COLS=4: single beat (255,255,last) -> out_acc=64991; (1,1,last) -> out_acc=1.
REQ-031 Exact build, ACC_WIDTH=16: beats (255,255),(255,255,last) -> out_acc=64514, out_ovf=1; next frame (2,2,last) -> out_acc=4, out_ovf=0.
REQ-032 Back-to-back: in_valid held high, 4 beats of (1,1) with last on 4th, out_ready held low 5 cycles -> in_ready=0 from acceptance of beat 4 until the out handshake, outputs stable in HOLD, then out_acc=4, out_count=4.
REQ-033 Reset mid-frame: accept (10,10),(20,20), assert rst one cycle, then (1,2,last) -> out_acc=2, out_count=1, no earlier result emitted.
REQ-034 Approx build, APPROX_COLS=0: random 1000 frames -> every out_acc matches exact sum of products.
